// File: rtl/fib_sched.sv
// -----------------------------------------------------------------------------
// fib_sched -- round-robin scheduler that shares one Fibonacci engine among
// NREQ requesters.
//
// One job at a time walks IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Rejected
// indices skip WAIT: IDLE -> ISSUE -> RESP -> IDLE. Every output is driven
// straight from a flop.
//
// Handshake semantics (documented once, here):
//   * A requester raises req_valid[k] with req_idx[k] and holds both until it
//     sees req_ack[k]. req_ack[k] is a one-cycle acceptance pulse. A request
//     dropped before it wins arbitration is simply never served.
//   * rsp_valid[k] is a one-cycle pulse. rsp_f/rsp_err qualify it and hold
//     until the next capture. The response cannot be back-pressured.
//   * Arbitration waits for fib_ready=1. fib_start is a one-cycle pulse with
//     fib_i. fib_done_tick/fib_f are only honoured while in WAIT.
//
// Ports
//   clk           in   single clock, rising edge
//   reset_n       in   synchronous active-low reset
//   req_valid     in   [NREQ]     per-requester request level
//   req_idx       in   [NREQ*IW]  packed indices, requester k at [k*IW +: IW]
//   req_ack       out  [NREQ]     acceptance pulse
//   rsp_valid     out  [NREQ]     response pulse
//   rsp_f         out  [FW]       result
//   rsp_err       out             error flag (bad index or timeout)
//   busy          out             state != IDLE
//   fib_start     out             engine start pulse
//   fib_i         out  [IW]       engine index
//   fib_ready     in              engine idle
//   fib_done_tick in              engine completion pulse
//   fib_f         in   [FW]       engine result
//   dbg_state     out  [2]        current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
// -----------------------------------------------------------------------------
module fib_sched #(
  parameter int NREQ = 4,
  parameter int IW   = 5,
  parameter int FW   = 20,
  parameter int MAXI = 30,
  parameter int TMO  = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*IW-1:0] req_idx,
  output logic [NREQ-1:0]    req_ack,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [FW-1:0]      rsp_f,
  output logic               rsp_err,
  output logic               busy,
  output logic               fib_start,
  output logic [IW-1:0]      fib_i,
  input  logic               fib_ready,
  input  logic               fib_done_tick,
  input  logic [FW-1:0]      fib_f,
  output logic [1:0]         dbg_state
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TMO + 1);
  localparam logic [IW:0] MAXI_X = (IW + 1)'(MAXI);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q;
  logic [GW-1:0]     last_grant_q;
  logic [GW-1:0]     win_q;
  logic              rej_q;
  logic [CW-1:0]     cnt_q;
  logic [NREQ-1:0]   req_ack_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [FW-1:0]     rsp_f_q;
  logic              rsp_err_q;
  logic              busy_q;
  logic              fib_start_q;
  logic [IW-1:0]     fib_i_q;

  logic              grant_vld_d;
  logic [GW-1:0]     grant_id_d;
  logic [GW-1:0]     cand;
  logic [IW-1:0]     idx_d;
  logic              idx_ok_d;

  // Successor of a requester id, wrapping at NREQ-1 (works for any NREQ).
  function automatic logic [GW-1:0] rr_next(input logic [GW-1:0] c);
    rr_next = (c == GW'(NREQ - 1)) ? '0 : c + GW'(1);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction

  // Round-robin search starting just after the last served requester.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_id_d  = '0;
    cand        = rr_next(last_grant_q);
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_vld_d && req_valid[cand]) begin
        grant_vld_d = 1'b1;
        grant_id_d  = cand;
      end
      cand = rr_next(cand);
    end
    idx_d    = req_idx[grant_id_d*IW +: IW];
    idx_ok_d = ({1'b0, idx_d} <= MAXI_X);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= GW'(NREQ - 1);
      win_q        <= '0;
      rej_q        <= 1'b0;
      cnt_q        <= '0;
      req_ack_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_f_q      <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      fib_start_q  <= 1'b0;
      fib_i_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_vld_d && fib_ready) begin
            win_q       <= grant_id_d;
            rej_q       <= !idx_ok_d;
            req_ack_q   <= onehot(grant_id_d);
            fib_start_q <= idx_ok_d;
            fib_i_q     <= idx_ok_d ? idx_d : '0;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          req_ack_q   <= '0;
          fib_start_q <= 1'b0;
          fib_i_q     <= '0;
          if (rej_q) begin
            // Out-of-range index never reaches the engine.
            rsp_valid_q <= onehot(win_q);
            rsp_f_q     <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Completion is checked before the timeout so done wins a tie.
          if (fib_done_tick) begin
            rsp_valid_q <= onehot(win_q);
            rsp_f_q     <= fib_f;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
            state_q     <= S_RESP;
          end else if (cnt_q == CW'(TMO - 1)) begin
            // This edge is the TMO-th one spent in WAIT.
            rsp_valid_q <= onehot(win_q);
            rsp_f_q     <= '0;
            rsp_err_q   <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RESP: begin
          rsp_valid_q  <= '0;
          last_grant_q <= win_q;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ack   = req_ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_f     = rsp_f_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign fib_start = fib_start_q;
  assign fib_i     = fib_i_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fib_sched.sv
// -----------------------------------------------------------------------------
// tb_fib_sched -- directed bench for fib_sched with a behavioural engine stub.
// -----------------------------------------------------------------------------
module tb_fib_sched;

  localparam int NREQ = 4;
  localparam int IW   = 5;
  localparam int FW   = 20;
  localparam int MAXI = 30;
  localparam int TMO  = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n   = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*IW-1:0] req_idx   = '0;
  logic [NREQ-1:0]    req_ack;
  logic [NREQ-1:0]    rsp_valid;
  logic [FW-1:0]      rsp_f;
  logic               rsp_err;
  logic               busy;
  logic               fib_start;
  logic [IW-1:0]      fib_i;
  logic               fib_ready;
  logic               fib_done_tick;
  logic [FW-1:0]      fib_f;
  logic [1:0]         dbg_state;

  fib_sched #(.NREQ(NREQ), .IW(IW), .FW(FW), .MAXI(MAXI), .TMO(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_idx(req_idx), .req_ack(req_ack),
    .rsp_valid(rsp_valid), .rsp_f(rsp_f), .rsp_err(rsp_err), .busy(busy),
    .fib_start(fib_start), .fib_i(fib_i), .fib_ready(fib_ready),
    .fib_done_tick(fib_done_tick), .fib_f(fib_f), .dbg_state(dbg_state)
  );

  // ---------------- engine stub ----------------
  int            eng_lat   = 2;
  bit            eng_hang  = 1'b0;
  bit            ready_en  = 1'b1;
  bit            spur_done = 1'b0;
  logic [FW-1:0] spur_f    = '0;
  bit            eng_busy  = 1'b0;
  bit            eng_done  = 1'b0;
  bit            eng_ready = 1'b1;
  int            eng_rem   = 0;
  logic [FW-1:0] eng_res   = '0;

  assign fib_ready     = eng_ready & ready_en;
  assign fib_done_tick = eng_done | spur_done;
  assign fib_f         = eng_done ? eng_res : spur_f;

  function automatic logic [FW-1:0] fib_calc(input logic [IW-1:0] n);
    int a, b, t;
    a = 0; b = 1;
    for (int i = 0; i < int'(n); i++) begin t = a + b; a = b; b = t; end
    return FW'(a);
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      eng_busy = 1'b0; eng_done = 1'b0; eng_ready = 1'b1; eng_rem = 0;
    end else begin
      eng_done = 1'b0;
      if (eng_busy) begin
        if (!eng_hang) begin
          eng_rem--;
          if (eng_rem <= 0) begin eng_done = 1'b1; eng_busy = 1'b0; eng_ready = 1'b1; end
        end
      end else if (fib_start) begin
        eng_busy = 1'b1; eng_ready = 1'b0; eng_rem = eng_lat; eng_res = fib_calc(fib_i);
      end
    end
  end

  // ---------------- monitor ----------------
  int            cyc = 0, start_cnt = 0, oh_viol = 0, gap_viol = 0;
  bit            prev_rsp = 1'b0;
  int            mon_ack_id[$], mon_ack_cyc[$], mon_rsp_id[$], mon_rsp_cyc[$];
  logic [FW-1:0] mon_rsp_f[$];
  logic          mon_rsp_err[$];
  logic [IW-1:0] mon_start_i[$];

  function automatic int oh2id(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
    return -1;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if ($countones(req_ack) > 1 || $countones(rsp_valid) > 1) oh_viol++;
    if (prev_rsp && (busy || (|req_ack))) gap_viol++;
    prev_rsp = |rsp_valid;
    if (|req_ack) begin mon_ack_id.push_back(oh2id(req_ack)); mon_ack_cyc.push_back(cyc); end
    if (fib_start) begin start_cnt++; mon_start_i.push_back(fib_i); end
    if (|rsp_valid) begin
      mon_rsp_id.push_back(oh2id(rsp_valid)); mon_rsp_cyc.push_back(cyc);
      mon_rsp_f.push_back(rsp_f); mon_rsp_err.push_back(rsp_err);
    end
  end

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [NREQ-1:0] drop_on_ack = '1;
  logic [FW-1:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req_valid = req_valid & ~(req_ack & drop_on_ack);
    end
  endtask

  task automatic set_req(input int k, input int idx);
    req_idx[k*IW +: IW] = IW'(idx);
    req_valid[k] = 1'b1;
  endtask

  task automatic wait_rsp(input int target, input int budget, output bit ok);
    int n;
    n = 0;
    while (mon_rsp_id.size() < target && n < budget) begin step(1); n++; end
    ok = (mon_rsp_id.size() >= target);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; req_valid = '0; eng_hang = 1'b0; eng_lat = 2;
    ready_en = 1'b1; spur_done = 1'b0; drop_on_ack = '1;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if (req_ack !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ack: got %b expected 0000", req_ack); end
    n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (fib_start !== 1'b0) begin n_fail++; $display("FAIL reset_fib_start: got %b expected 0", fib_start); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    int a, b, s; bit ok;
    do_reset();
    a = mon_ack_id.size(); b = mon_rsp_id.size(); s = start_cnt;
    set_req(0, 9);
    wait_rsp(b + 1, 200, ok);
    step(2);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_rsp_seen: got %b expected 1", ok); end
    n_checks++; if (mon_ack_id.size() - a !== 1) begin n_fail++; $display("FAIL single_ack_count: got %0d expected 1", mon_ack_id.size() - a); end
    n_checks++; if (mon_ack_id[a] !== 0) begin n_fail++; $display("FAIL single_ack_id: got %0d expected 0", mon_ack_id[a]); end
    n_checks++; if (start_cnt - s !== 1) begin n_fail++; $display("FAIL single_start_count: got %0d expected 1", start_cnt - s); end
    n_checks++; if (mon_start_i[s] !== 5'd9) begin n_fail++; $display("FAIL single_fib_i: got %0d expected 9", mon_start_i[s]); end
    n_checks++; if (mon_rsp_id[b] !== 0) begin n_fail++; $display("FAIL single_rsp_id: got %0d expected 0", mon_rsp_id[b]); end
    n_checks++; if (mon_rsp_f[b] !== 20'd34) begin n_fail++; $display("FAIL single_rsp_f: got %0d expected 34", mon_rsp_f[b]); end
    n_checks++; if (mon_rsp_err[b] !== 1'b0) begin n_fail++; $display("FAIL single_rsp_err: got %b expected 0", mon_rsp_err[b]); end
    n_checks++; if ((mon_rsp_cyc[b] - mon_ack_cyc[a] >= 2) !== 1'b1) begin n_fail++; $display("FAIL single_spacing: got %0d expected >=2", mon_rsp_cyc[b] - mon_ack_cyc[a]); end
  endtask

  task automatic test_all_four();
    int b; bit ok; logic [FW-1:0] e;
    do_reset();
    b = mon_rsp_id.size();
    exp_q = {20'd3, 20'd5, 20'd8, 20'd13};
    set_req(0, 4); set_req(1, 5); set_req(2, 6); set_req(3, 7);
    wait_rsp(b + 4, 400, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL four_rsp_seen: got %b expected 1", ok); end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_checks++; if (mon_rsp_id[b+i] !== i) begin n_fail++; $display("FAIL four_order[%0d]: got %0d expected %0d", i, mon_rsp_id[b+i], i); end
      n_checks++; if (mon_rsp_f[b+i] !== e) begin n_fail++; $display("FAIL four_rsp_f[%0d]: got %0d expected %0d", i, mon_rsp_f[b+i], e); end
    end
  endtask

  task automatic test_round_robin();
    int a, b, n; bit ok;
    do_reset();
    drop_on_ack = 4'b1010;
    a = mon_ack_id.size(); b = mon_rsp_id.size();
    set_req(0, 1); set_req(2, 2);
    n = 0;
    while (mon_ack_id.size() < a + 4 && n < 400) begin step(1); n++; end
    req_valid = '0;
    wait_rsp(b + 4, 200, ok);
    step(4);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rr_rsp_seen: got %b expected 1", ok); end
    n_checks++; if (mon_ack_id.size() - a !== 4) begin n_fail++; $display("FAIL rr_ack_count: got %0d expected 4", mon_ack_id.size() - a); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (mon_ack_id[a+i] !== 2 * (i % 2)) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", i, mon_ack_id[a+i], 2 * (i % 2)); end
    end
  endtask

  task automatic test_boundary();
    int a, b, s; bit ok;
    do_reset();
    b = mon_rsp_id.size(); s = start_cnt;
    set_req(0, 30);
    wait_rsp(b + 1, 200, ok);
    n_checks++; if (mon_start_i[s] !== 5'd30) begin n_fail++; $display("FAIL bnd30_fib_i: got %0d expected 30", mon_start_i[s]); end
    n_checks++; if (mon_rsp_f[b] !== 20'd832040) begin n_fail++; $display("FAIL bnd30_rsp_f: got %0d expected 832040", mon_rsp_f[b]); end
    n_checks++; if (mon_rsp_err[b] !== 1'b0) begin n_fail++; $display("FAIL bnd30_rsp_err: got %b expected 0", mon_rsp_err[b]); end
    step(3);
    n_checks++; if (rsp_f !== 20'd832040) begin n_fail++; $display("FAIL bnd30_hold: got %0d expected 832040", rsp_f); end
    b = mon_rsp_id.size();
    set_req(0, 0);
    wait_rsp(b + 1, 200, ok);
    n_checks++; if (mon_rsp_f[b] !== 20'd0) begin n_fail++; $display("FAIL bnd0_rsp_f: got %0d expected 0", mon_rsp_f[b]); end
    n_checks++; if (mon_rsp_err[b] !== 1'b0) begin n_fail++; $display("FAIL bnd0_rsp_err: got %b expected 0", mon_rsp_err[b]); end
    step(2);
    a = mon_ack_id.size(); b = mon_rsp_id.size(); s = start_cnt;
    set_req(1, 31);
    wait_rsp(b + 1, 200, ok);
    step(3);
    n_checks++; if (mon_ack_id[a] !== 1) begin n_fail++; $display("FAIL bnd31_ack_id: got %0d expected 1", mon_ack_id[a]); end
    n_checks++; if (start_cnt - s !== 0) begin n_fail++; $display("FAIL bnd31_no_start: got %0d expected 0", start_cnt - s); end
    n_checks++; if (mon_rsp_id[b] !== 1) begin n_fail++; $display("FAIL bnd31_rsp_id: got %0d expected 1", mon_rsp_id[b]); end
    n_checks++; if (mon_rsp_f[b] !== 20'd0) begin n_fail++; $display("FAIL bnd31_rsp_f: got %0d expected 0", mon_rsp_f[b]); end
    n_checks++; if (mon_rsp_err[b] !== 1'b1) begin n_fail++; $display("FAIL bnd31_rsp_err: got %b expected 1", mon_rsp_err[b]); end
    n_checks++; if (mon_rsp_cyc[b] - mon_ack_cyc[a] !== 1) begin n_fail++; $display("FAIL bnd31_spacing: got %0d expected 1", mon_rsp_cyc[b] - mon_ack_cyc[a]); end
    n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL bnd31_err_hold: got %b expected 1", rsp_err); end
  endtask

  task automatic test_ready_low();
    int a, b; bit ok;
    do_reset();
    ready_en = 1'b0;
    a = mon_ack_id.size(); b = mon_rsp_id.size();
    set_req(0, 3);
    step(10);
    n_checks++; if (mon_ack_id.size() - a !== 0) begin n_fail++; $display("FAIL notready_ack: got %0d expected 0", mon_ack_id.size() - a); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL notready_busy: got %b expected 0", busy); end
    ready_en = 1'b1;
    wait_rsp(b + 1, 200, ok);
    n_checks++; if (mon_rsp_f[b] !== 20'd2) begin n_fail++; $display("FAIL notready_rsp_f: got %0d expected 2", mon_rsp_f[b]); end
  endtask

  task automatic test_spurious_done();
    int b;
    step(3);
    b = mon_rsp_id.size();
    spur_f = 20'd777; spur_done = 1'b1;
    step(1);
    spur_done = 1'b0;
    step(3);
    n_checks++; if (mon_rsp_id.size() - b !== 0) begin n_fail++; $display("FAIL spur_rsp: got %0d expected 0", mon_rsp_id.size() - b); end
    n_checks++; if (rsp_f !== 20'd2) begin n_fail++; $display("FAIL spur_rsp_f: got %0d expected 2", rsp_f); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL spur_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_timeout();
    int a, b; bit ok;
    do_reset();
    b = mon_rsp_id.size();
    set_req(0, 9);
    wait_rsp(b + 1, 200, ok);
    step(2);
    eng_hang = 1'b1;
    a = mon_ack_id.size(); b = mon_rsp_id.size();
    set_req(0, 5);
    wait_rsp(b + 1, 300, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tmo_rsp_seen: got %b expected 1", ok); end
    n_checks++; if (mon_rsp_err[b] !== 1'b1) begin n_fail++; $display("FAIL tmo_rsp_err: got %b expected 1", mon_rsp_err[b]); end
    n_checks++; if (mon_rsp_f[b] !== 20'd0) begin n_fail++; $display("FAIL tmo_rsp_f: got %0d expected 0", mon_rsp_f[b]); end
    n_checks++; if (mon_rsp_cyc[b] - mon_ack_cyc[a] !== 65) begin n_fail++; $display("FAIL tmo_latency: got %0d expected 65", mon_rsp_cyc[b] - mon_ack_cyc[a]); end
    step(2);
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL tmo_back_idle: got %0d expected 0", dbg_state); end
    do_reset();
    eng_lat = 64;
    a = mon_ack_id.size(); b = mon_rsp_id.size();
    set_req(0, 5);
    wait_rsp(b + 1, 300, ok);
    n_checks++; if (mon_rsp_err[b] !== 1'b0) begin n_fail++; $display("FAIL tmo_tie_err: got %b expected 0", mon_rsp_err[b]); end
    n_checks++; if (mon_rsp_f[b] !== 20'd5) begin n_fail++; $display("FAIL tmo_tie_f: got %0d expected 5", mon_rsp_f[b]); end
    n_checks++; if (mon_rsp_cyc[b] - mon_ack_cyc[a] !== 65) begin n_fail++; $display("FAIL tmo_tie_latency: got %0d expected 65", mon_rsp_cyc[b] - mon_ack_cyc[a]); end
  endtask

  task automatic test_reset_mid_wait();
    int a, b, n; bit ok;
    do_reset();
    b = mon_rsp_id.size();
    set_req(0, 9);
    wait_rsp(b + 1, 200, ok);
    n_checks++; if (rsp_f !== 20'd34) begin n_fail++; $display("FAIL midrst_pre_f: got %0d expected 34", rsp_f); end
    step(2);
    eng_hang = 1'b1;
    a = mon_ack_id.size();
    set_req(1, 5);
    n = 0;
    while (mon_ack_id.size() <= a && n < 50) begin step(1); n++; end
    step(3);
    n_checks++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL midrst_in_wait: got %0d expected 2", dbg_state); end
    b = mon_rsp_id.size();
    reset_n = 1'b0; req_valid = '0;
    step(1);
    n_checks++; if (rsp_f !== 20'd0) begin n_fail++; $display("FAIL midrst_rsp_f: got %0d expected 0", rsp_f); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp_err: got %b expected 0", rsp_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL midrst_rsp_valid: got %b expected 0000", rsp_valid); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL midrst_state: got %0d expected 0", dbg_state); end
    reset_n = 1'b1; eng_hang = 1'b0;
    step(80);
    n_checks++; if (mon_rsp_id.size() - b !== 0) begin n_fail++; $display("FAIL midrst_no_rsp: got %0d expected 0", mon_rsp_id.size() - b); end
    a = mon_ack_id.size(); b = mon_rsp_id.size();
    set_req(0, 2); set_req(1, 3);
    wait_rsp(b + 2, 300, ok);
    n_checks++; if (mon_ack_id[a] !== 0) begin n_fail++; $display("FAIL midrst_first_grant: got %0d expected 0", mon_ack_id[a]); end
    n_checks++; if (mon_rsp_f[b+1] !== 20'd2) begin n_fail++; $display("FAIL midrst_second_f: got %0d expected 2", mon_rsp_f[b+1]); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_round_robin();
    test_boundary();
    test_ready_low();
    test_spurious_done();
    test_timeout();
    test_reset_mid_wait();
    step(2);
    n_checks++; if (oh_viol !== 0) begin n_fail++; $display("FAIL onehot_pulses: got %0d violations expected 0", oh_viol); end
    n_checks++; if (gap_viol !== 0) begin n_fail++; $display("FAIL idle_gap: got %0d violations expected 0", gap_viol); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
